// File: rtl/if_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs a req/ack handshake to
// instruction memory, and holds each fetched instruction until decode takes it.
module if_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              ce_o,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              kill;
  logic [ADDR_W-1:0] kill_tgt;
  logic              ce;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values and the case arms can be read in any order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      kill_tgt   <= '0;
      ce         <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          ce    <= 1'b1;
        end

        REQ: begin
          if (branch_flag_i) begin
            if (mem_ack_i) begin
              // In-flight data belongs to the old path; restart at the target.
              pc   <= branch_target_i;
              kill <= 1'b0;
            end else begin
              // Cannot abort a pending transfer: remember where to go after ack.
              kill     <= 1'b1;
              kill_tgt <= branch_target_i;
            end
          end else if (mem_ack_i) begin
            if (kill) begin
              pc   <= kill_tgt;
              kill <= 1'b0;
            end else begin
              inst       <= mem_rdata_i;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + PC_STEP;
              state      <= HOLD;
            end
          end
        end

        HOLD: begin
          if (branch_flag_i) begin
            inst_valid <= 1'b0;
            pc         <= branch_target_i;
            state      <= REQ;
          end else if (!stall_i) begin
            inst_valid <= 1'b0;
            state      <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req_o    = (state == REQ);
  assign mem_addr_o   = pc;
  assign ce_o         = ce;
  assign inst_valid_o = inst_valid;
  assign inst_o       = inst;
  assign inst_pc_o    = inst_pc;

endmodule

// File: tb/tb_if_ctrl.sv
// Bench for if_ctrl: directed fetch/branch/reset scenarios followed by random
// stimulus, all outputs compared each cycle against a transaction-level model.
module tb_if_ctrl;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_i;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              ce_o;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;

  if_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ack_i      (mem_ack_i),
    .mem_rdata_i    (mem_rdata_i),
    .ce_o           (ce_o),
    .inst_valid_o   (inst_valid_o),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Reference model, expressed as fetch transactions rather than FSM states.
  bit          m_known = 0;
  bit          m_started;
  bit          m_fetching;
  bit          m_slot_full;
  bit          m_redirect;
  bit          m_ce;
  logic [31:0] m_fetch_addr;
  logic [31:0] m_redirect_to;
  logic [31:0] m_inst;
  logic [31:0] m_inst_pc;

  task automatic model_update(input bit r, input bit s, input bit b,
                              input logic [31:0] t, input bit a);
    if (!r) begin
      m_known      = 1;
      m_started    = 0;
      m_fetching   = 0;
      m_slot_full  = 0;
      m_redirect   = 0;
      m_ce         = 0;
      m_fetch_addr = RESET_PC;
      m_redirect_to = '0;
      m_inst       = '0;
      m_inst_pc    = '0;
    end else if (!m_started) begin
      m_started  = 1;
      m_fetching = 1;
      m_ce       = 1;
    end else if (m_fetching) begin
      if (b && a) begin
        m_fetch_addr = t;
        m_redirect   = 0;
      end else if (b) begin
        m_redirect    = 1;
        m_redirect_to = t;
      end else if (a && m_redirect) begin
        m_fetch_addr = m_redirect_to;
        m_redirect   = 0;
      end else if (a) begin
        m_inst       = mem_data(m_fetch_addr);
        m_inst_pc    = m_fetch_addr;
        m_slot_full  = 1;
        m_fetching   = 0;
        m_fetch_addr = m_fetch_addr + 32'd4;
      end
    end else if (m_slot_full) begin
      if (b) begin
        m_fetch_addr = t;
        m_slot_full  = 0;
        m_fetching   = 1;
      end else if (!s) begin
        m_slot_full = 0;
        m_fetching  = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("mem_req",    32'(mem_req_o),    32'(m_fetching));
    check("mem_addr",   mem_addr_o,        m_fetch_addr);
    check("ce",         32'(ce_o),         32'(m_ce));
    check("inst_valid", 32'(inst_valid_o), 32'(m_slot_full));
    check("inst",       inst_o,            m_inst);
    check("inst_pc",    inst_pc_o,         m_inst_pc);
  endtask

  // One clock: drive inputs, advance the model, then sample on the falling edge.
  task automatic cycle(input bit r, input bit s, input bit b,
                       input logic [31:0] t, input bit a);
    rst             = r;
    stall_i         = s;
    branch_flag_i   = b;
    branch_target_i = t;
    mem_ack_i       = a;
    mem_rdata_i     = mem_data(mem_addr_o);
    model_update(r, s, b, t, a);
    @(posedge clk);
    @(negedge clk);
    if (m_known) compare_all();
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, '0, 0);
    cycle(0, 0, 0, '0, 0);
    check("rst_req",   32'(mem_req_o),    32'd0);
    check("rst_ce",    32'(ce_o),         32'd0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst",  inst_o,            32'd0);
    cycle(1, 0, 0, '0, 0);
    check("first_req", 32'(mem_req_o), 32'd1);
    check("first_ce",  32'(ce_o),      32'd1);
  endtask

  int lat;
  bit r_in, a_in, b_in;
  logic [31:0] t_in;

  initial begin
    rst = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0;
    branch_target_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk);

    // Zero-wait memory, no stall: one instruction every two cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("zw_addr", mem_addr_o, 32'(i * 4));
      cycle(1, 0, 0, '0, 1);
      check("zw_valid", 32'(inst_valid_o), 32'd1);
      check("zw_pc",    inst_pc_o,         32'(i * 4));
      cycle(1, 0, 0, '0, 0);
    end

    // Three-cycle memory latency, then a four-cycle stall on a full slot.
    do_reset();
    cycle(1, 0, 0, '0, 1);
    cycle(1, 0, 0, '0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, '0, 0);
      check("lat_addr", mem_addr_o, 32'h4);
    end
    cycle(1, 0, 0, '0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, '0, 0);
      check("stall_valid", 32'(inst_valid_o), 32'd1);
      check("stall_pc",    inst_pc_o,         32'h4);
      check("stall_inst",  inst_o,            mem_data(32'h4));
    end
    cycle(1, 0, 0, '0, 0);
    check("post_stall_addr", mem_addr_o, 32'h8);

    // Branch while a fetch to 0x8 is pending; the acked data is discarded.
    cycle(1, 0, 1, 32'h100, 0);
    cycle(1, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 1);
    check("kill_valid", 32'(inst_valid_o), 32'd0);
    check("kill_addr",  mem_addr_o,        32'h100);
    cycle(1, 0, 0, '0, 1);
    check("kill_pc", inst_pc_o, 32'h100);

    // Two branches during one pending fetch: the latest target wins.
    do_reset();
    cycle(1, 0, 1, 32'h200, 0);
    cycle(1, 0, 1, 32'h300, 0);
    cycle(1, 0, 0, '0, 0);
    check("dbl_hold_addr", mem_addr_o, 32'h0);
    cycle(1, 0, 0, '0, 1);
    check("dbl_addr", mem_addr_o, 32'h300);
    cycle(1, 0, 0, '0, 1);
    check("dbl_pc", inst_pc_o, 32'h300);

    // Branch in HOLD under stall, then branch coincident with ack.
    do_reset();
    cycle(1, 0, 0, '0, 1);
    cycle(1, 1, 1, 32'h40, 0);
    check("hold_br_valid", 32'(inst_valid_o), 32'd0);
    check("hold_br_addr",  mem_addr_o,        32'h40);
    cycle(1, 0, 1, 32'h80, 1);
    check("ack_br_valid", 32'(inst_valid_o), 32'd0);
    check("ack_br_addr",  mem_addr_o,        32'h80);

    // Reset during an outstanding request, then PC wrap at the top of memory.
    cycle(0, 0, 0, '0, 0);
    check("midrst_req", 32'(mem_req_o), 32'd0);
    check("midrst_ce",  32'(ce_o),      32'd0);
    cycle(1, 0, 0, '0, 0);
    check("restart_addr", mem_addr_o, 32'h0);
    cycle(1, 0, 1, 32'hFFFF_FFFC, 1);
    cycle(1, 0, 0, '0, 1);
    check("wrap_pc", inst_pc_o, 32'hFFFF_FFFC);
    cycle(1, 0, 0, '0, 0);
    check("wrap_addr", mem_addr_o, 32'h0);

    // Random traffic with variable memory latency.
    lat = 0;
    for (int i = 0; i < 4000; i++) begin
      r_in = ($urandom_range(0, 99) != 0);
      if (!mem_req_o) begin
        a_in = 0;
        lat  = $urandom_range(0, 3);
      end else if (lat == 0) begin
        a_in = 1;
        lat  = $urandom_range(0, 3);
      end else begin
        a_in = 0;
        lat--;
      end
      b_in = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       t_in = 32'hFFFF_FFFC;
        1:       t_in = $urandom;
        default: t_in = $urandom & 32'h0000_0FFC;
      endcase
      cycle(r_in, $urandom_range(0, 9) < 3, b_in, t_in, a_in);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
